// File: rtl/can_tx_framer.sv
// CAN 2.0A base-frame transmitter: one bit per clk, with bit stuffing, CRC-15,
// arbitration and bit monitoring, and an ACK-slot check.
module can_tx_framer #(
  parameter int IFS_BITS = 3,
  parameter int EOF_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        txValid,
  output logic        txReady,
  input  logic [10:0] txId,
  input  logic        txRtr,
  input  logic [3:0]  txDlc,
  input  logic [63:0] txPayload,
  output logic        canTx,
  input  logic        canRx,
  output logic        busy,
  output logic        txDone,
  output logic        ackErr,
  output logic        arbLost,
  output logic        bitErr
);

  // state  | meaning
  // IDLE   | no frame in progress, txReady high
  // ARB    | SOF, identifier, RTR; recessive bits watched for arbitration loss
  // CTRL   | IDE, r0, DLC
  // DATA   | payload bits, byte0 MSB first
  // CRC    | CRC-15 sequence, plus a trailing stuff bit when one is due
  // CRCDEL | CRC delimiter
  // ACK    | ACK slot, bus sampled for a dominant acknowledge
  // ACKDEL | ACK delimiter
  // EOF    | end of frame, EOF_BITS recessive bits
  // IFS    | intermission, IFS_BITS recessive bits; result pulsed on the last
  typedef enum logic [3:0] {
    IDLE,
    ARB,
    CTRL,
    DATA,
    CRC,
    CRCDEL,
    ACK,
    ACKDEL,
    EOF,
    IFS
  } state_t;

  localparam logic [7:0]  EOF_TC   = 8'(EOF_BITS - 1);
  localparam logic [7:0]  IFS_TC   = 8'(IFS_BITS - 1);
  localparam logic [14:0] CRC_POLY = 15'h4599;

  state_t      state;
  state_t      stateNext;
  logic [7:0]  bitCnt;
  logic [7:0]  bitCntNext;
  logic [10:0] idReg;
  logic        rtrReg;
  logic [3:0]  dlcReg;
  logic [63:0] dataReg;
  logic [63:0] dataNext;
  logic [14:0] crcReg;
  logic [14:0] crcNext;
  logic [2:0]  runLen;
  logic [2:0]  runLenNext;
  logic        lastBit;
  logic        lastBitNext;
  logic        crcTail;
  logic        crcTailNext;
  logic        ackSeen;
  logic        ackSeenNext;

  logic        accept;
  logic        stuffZone;
  logic        stuffNow;
  logic        fieldBit;
  logic        txBit;
  logic [2:0]  runStep;
  logic [14:0] crcStep;
  logic [12:0] arbVec;
  logic [5:0]  ctrlVec;
  logic [3:0]  nBytes;
  logic [7:0]  dataTc;
  logic        arbHit;
  logic        bitHit;
  logic        lastIfs;

  assign arbVec  = {1'b0, idReg, rtrReg};
  assign ctrlVec = {2'b00, dlcReg};
  assign nBytes  = rtrReg ? 4'd0 : ((dlcReg > 4'd8) ? 4'd8 : dlcReg);
  assign dataTc  = {1'b0, nBytes, 3'b000} - 8'd1;

  assign accept    = txValid && txReady && !rst;
  assign stuffZone = state inside {ARB, CTRL, DATA, CRC};
  assign stuffNow  = (runLen == 3'd5);

  always_comb begin
    fieldBit = 1'b1;
    unique case (state)
      ARB:     fieldBit = arbVec[bitCnt[3:0]];
      CTRL:    fieldBit = ctrlVec[bitCnt[2:0]];
      DATA:    fieldBit = dataReg[63];
      CRC:     fieldBit = crcReg[bitCnt[3:0]];
      default: fieldBit = 1'b1;
    endcase
  end

  // A stuff bit replaces the field bit for one cycle; field counters hold.
  assign txBit   = stuffNow ? ~lastBit : fieldBit;
  assign runStep = (txBit == lastBit) ? runLen + 3'd1 : 3'd1;
  assign crcStep = {crcReg[13:0], 1'b0} ^ ((crcReg[14] ^ fieldBit) ? CRC_POLY : 15'h0000);

  assign arbHit  = (state == ARB) && txBit && !canRx;
  assign bitHit  = (state inside {CTRL, DATA, CRC}) && (canRx != txBit);
  assign lastIfs = (state == IFS) && (bitCnt == 8'd0);

  assign busy    = (state != IDLE) && !rst;
  assign txReady = !busy;
  assign canTx   = (rst || !stuffZone) ? 1'b1 : txBit;
  assign arbLost = arbHit && !rst;
  assign bitErr  = bitHit && !rst;
  assign txDone  = lastIfs && ackSeen && !rst;
  assign ackErr  = lastIfs && !ackSeen && !rst;

  always_comb begin
    stateNext   = state;
    bitCntNext  = bitCnt;
    dataNext    = dataReg;
    crcNext     = crcReg;
    runLenNext  = runLen;
    lastBitNext = lastBit;
    crcTailNext = crcTail;
    ackSeenNext = ackSeen;

    if (stuffZone) begin
      runLenNext  = runStep;
      lastBitNext = txBit;
      if (!stuffNow) begin
        bitCntNext = bitCnt - 8'd1;
        if (state != CRC) begin
          crcNext = crcStep;
        end
        if (state == DATA) begin
          dataNext = {dataReg[62:0], 1'b0};
        end
      end
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          stateNext   = ARB;
          bitCntNext  = 8'd12;
          dataNext    = txPayload;
          crcNext     = 15'h0000;
          runLenNext  = 3'd0;
          lastBitNext = 1'b1;
          crcTailNext = 1'b0;
          ackSeenNext = 1'b0;
        end
      end
      ARB: begin
        if (arbHit) begin
          stateNext = IDLE;
        end else if (!stuffNow && bitCnt == 8'd0) begin
          stateNext  = CTRL;
          bitCntNext = 8'd5;
        end
      end
      CTRL: begin
        if (bitHit) begin
          stateNext = IDLE;
        end else if (!stuffNow && bitCnt == 8'd0) begin
          if (nBytes == 4'd0) begin
            stateNext  = CRC;
            bitCntNext = 8'd14;
          end else begin
            stateNext  = DATA;
            bitCntNext = dataTc;
          end
        end
      end
      DATA: begin
        if (bitHit) begin
          stateNext = IDLE;
        end else if (!stuffNow && bitCnt == 8'd0) begin
          stateNext  = CRC;
          bitCntNext = 8'd14;
        end
      end
      CRC: begin
        // A run completed by the last CRC bit still earns its stuff bit.
        if (bitHit) begin
          stateNext = IDLE;
        end else if (stuffNow) begin
          if (crcTail) begin
            stateNext = CRCDEL;
          end
        end else if (bitCnt == 8'd0) begin
          if (runStep == 3'd5) begin
            crcTailNext = 1'b1;
          end else begin
            stateNext = CRCDEL;
          end
        end
      end
      CRCDEL: stateNext = ACK;
      ACK: begin
        ackSeenNext = !canRx;
        stateNext   = ACKDEL;
      end
      ACKDEL: begin
        stateNext  = EOF;
        bitCntNext = EOF_TC;
      end
      EOF: begin
        if (bitCnt == 8'd0) begin
          stateNext  = IFS;
          bitCntNext = IFS_TC;
        end else begin
          bitCntNext = bitCnt - 8'd1;
        end
      end
      IFS: begin
        if (bitCnt == 8'd0) begin
          stateNext = IDLE;
        end else begin
          bitCntNext = bitCnt - 8'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bitCnt  <= 8'd0;
      dataReg <= 64'h0;
      crcReg  <= 15'h0000;
      runLen  <= 3'd0;
      lastBit <= 1'b1;
      crcTail <= 1'b0;
      ackSeen <= 1'b0;
      idReg   <= 11'h000;
      rtrReg  <= 1'b0;
      dlcReg  <= 4'd0;
    end else begin
      state   <= stateNext;
      bitCnt  <= bitCntNext;
      dataReg <= dataNext;
      crcReg  <= crcNext;
      runLen  <= runLenNext;
      lastBit <= lastBitNext;
      crcTail <= crcTailNext;
      ackSeen <= ackSeenNext;
      if (accept) begin
        idReg  <= txId;
        rtrReg <= txRtr;
        dlcReg <= txDlc;
      end
    end
  end

endmodule

// File: doc/can_tx_framer.md
CAN_TX_FRAMER -- requirements
Module: can_tx_framer

Interface
REQ-001 SHALL have parameter IFS_BITS, default 3: number of recessive intermission bits after EOF.
REQ-002 SHALL have parameter EOF_BITS, default 7: number of recessive end-of-frame bits.
REQ-003 SHALL have port clk  input  1: the block's only clock; one CAN bit time per clk cycle.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port txValid  input  1: frame request valid.
REQ-006 SHALL have port txReady  output  1: block can accept a frame.
REQ-007 SHALL have port txId  input  11: standard identifier.
REQ-008 SHALL have port txRtr  input  1: remote request flag.
REQ-009 SHALL have port txDlc  input  4: data length code.
REQ-010 SHALL have port txPayload  input  64: data; byte0 = [63:56], sent first.
REQ-011 SHALL have port canTx  output  1: serial bus output, 1 = recessive.
REQ-012 SHALL have port canRx  input  1: bus level read back from the PHY in the same cycle.
REQ-013 SHALL have port busy  output  1: frame in progress.
REQ-014 SHALL have port txDone  output  1: one-cycle pulse, frame sent and acknowledged.
REQ-015 SHALL have port ackErr  output  1: one-cycle pulse, no dominant ACK seen.
REQ-016 SHALL have port arbLost  output  1: one-cycle pulse, arbitration lost.
REQ-017 SHALL have port bitErr  output  1: one-cycle pulse, bus readback mismatch.

Function
REQ-018 SHALL accept a frame on a posedge with txValid && txReady, registering all tx* inputs, and SHALL hold txReady high only in IDLE.
REQ-019 SHALL drive SOF (0) on canTx in the cycle after acceptance, then bits MSB-first in this order: ID[10:0], RTR, IDE=0, r0=0, DLC[3:0], data, CRC[14:0].
REQ-020 SHALL send min(txDlc,8) data bytes, or none when txRtr=1; the DLC field is always sent as given, including values 9-15.
REQ-021 SHALL compute CRC-15 (polynomial 0x4599, init 0) over the unstuffed bits SOF through the last data bit.
REQ-022 SHALL insert a complement stuff bit after every 5 consecutive identical transmitted bits from SOF through the CRC end; stuff bits count toward later runs; no stuffing from the CRC delimiter onward.
REQ-023 SHALL step the state machine IDLE -> ARB (SOF, ID, RTR) -> CTRL -> DATA (skipped if 0 bytes) -> CRC -> CRCDEL -> ACK -> ACKDEL -> EOF -> IFS -> IDLE; stuff bits do not advance field counters.
REQ-024 SHALL drive canTx=1 in CRCDEL, ACK, ACKDEL, EOF (EOF_BITS cycles) and IFS (IFS_BITS cycles).
REQ-025 SHALL, in ARB, on a cycle where canTx=1 and canRx=0 (stuff bits included), pulse arbLost, drive canTx=1 from the next cycle, and return to IDLE.
REQ-026 SHALL, in CTRL through CRC, on canRx != canTx, pulse bitErr and return to IDLE with canTx=1.
REQ-027 SHALL sample canRx in the ACK cycle; if 0, pulse txDone in the last IFS cycle; if 1, pulse ackErr in that cycle and still complete ACKDEL/EOF/IFS.
REQ-028 SHALL drive busy high from the acceptance cycle's successor until return to IDLE, and drive txReady as the complement of busy.
REQ-029 SHALL never assert txDone, ackErr, arbLost and bitErr in the same cycle.

Reset
REQ-030 SHALL, with rst high, force IDLE, canTx=1, txReady=1, busy=0, all pulse outputs 0, and clear stuff and CRC state; this holds mid-frame, and the aborted frame produces no pulse.
REQ-031 SHALL ignore txValid in any cycle where rst is high.

Verification
REQ-032 SHALL cover id=0x123, rtr=0, dlc=0, canRx=canTx except ACK=0 -> canTx = 0,00100100011,0,0,0,0000 with stuff 1 after the 5-zero run, then CRC matching a software model; txDone pulses once.
REQ-033 SHALL cover dlc=8, payload=0x0123456789ABCDEF with loopback and dominant ACK -> destuffed data field equals the payload MSB-first, busy high for the full frame length, txDone pulses once.
REQ-034 SHALL cover the same frame with canRx tied to canTx (no ACK) -> ackErr pulses once, txDone never, and EOF plus IFS are still sent.
REQ-035 SHALL cover id=0x7FF with canRx forced 0 during ID bit 5 -> arbLost pulses, canTx=1 from the next cycle, and txReady high 1 cycle later.
REQ-036 SHALL cover rst asserted during DATA -> canTx=1 and txReady=1 in the next cycle with no pulses, and a following frame with dlc=1 completes normally.
REQ-037 SHALL cover rtr=1, dlc=4 -> DLC 0100 is sent, no data bits follow, and CRC comes immediately after DLC.
